score_calculator: RTL and testbench



---
 rtl/score_calculator_pkg.sv | 31 +++
 rtl/score_calculator_if.sv | 31 +++
 rtl/score_calculator_bcd2_add_sat.sv | 39 +++
 rtl/score_calculator.sv | 144 ++++++++++++++
 tb/tb_score_calculator.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/score_calculator_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types, widths and parameter-range helpers for the score calculator.
// No ports; imported by the interface, the BCD adder and the top.
// -----------------------------------------------------------------------------
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  typedef logic [3:0] bcd_t;

  localparam int SCORE_W = 7;
  localparam int LIVES_W = 3;

  function automatic bit points_ok(input int p);
    return (p >= 1) && (p <= 9);
  endfunction

  function automatic bit lives_ok(input int l);
    return (l >= 1) && (l <= 7);
  endfunction

  function automatic bit max_score_ok(input int s);
    return (s >= 0) && (s <= 99);
  endfunction

endpackage

// File: rtl/score_calculator_if.sv
// -----------------------------------------------------------------------------
// score_calculator_if
// Groups the game event inputs and the frame-stable score outputs.
//   master : drives game_start/hit/miss/frame_start, reads the outputs
//   slave  : the score calculator itself
// -----------------------------------------------------------------------------
interface score_calculator_if;
  import score_pkg::*;

  logic                game_start;
  logic                hit;
  logic                miss;
  logic                frame_start;
  logic [SCORE_W-1:0]  score;
  bcd_t                digit_tens;
  bcd_t                digit_ones;
  logic [LIVES_W-1:0]  lives_left;
  logic                playing;
  logic                game_over;

  modport master (
    output game_start, hit, miss, frame_start,
    input  score, digit_tens, digit_ones, lives_left, playing, game_over
  );

  modport slave (
    input  game_start, hit, miss, frame_start,
    output score, digit_tens, digit_ones, lives_left, playing, game_over
  );

endinterface

// File: rtl/score_calculator_bcd2_add_sat.sv
// -----------------------------------------------------------------------------
// bcd2_add_sat
// Combinational two-digit BCD add with saturation at a ceiling.
//   i_tens, i_ones         : current BCD value
//   i_addend               : 0..9 added to the ones digit
//   i_max_tens, i_max_ones : ceiling as BCD digits (ceiling <= 99)
//   o_tens, o_ones         : min(value + addend, ceiling) as BCD
// -----------------------------------------------------------------------------
module bcd2_add_sat
  import score_pkg::*;
(
  input  bcd_t       i_tens,
  input  bcd_t       i_ones,
  input  logic [3:0] i_addend,
  input  bcd_t       i_max_tens,
  input  bcd_t       i_max_ones,
  output bcd_t       o_tens,
  output bcd_t       o_ones
);

  logic [4:0] w_ones_sum;
  logic       w_carry;
  bcd_t       w_ones_adj;
  logic [4:0] w_tens_sum;
  logic       w_over;

  assign w_ones_sum = {1'b0, i_ones} + {1'b0, i_addend};
  assign w_carry    = (w_ones_sum >= 5'd10);
  assign w_ones_adj = w_carry ? 4'(w_ones_sum - 5'd10) : w_ones_sum[3:0];
  assign w_tens_sum = {1'b0, i_tens} + {4'b0000, w_carry};

  // Tens may reach 10 here; any tens above the ceiling saturates.
  assign w_over = (w_tens_sum > {1'b0, i_max_tens}) ||
                  ((w_tens_sum == {1'b0, i_max_tens}) && (w_ones_adj > i_max_ones));

  assign o_tens = w_over ? i_max_tens : w_tens_sum[3:0];
  assign o_ones = w_over ? i_max_ones : w_ones_adj;

endmodule

// File: rtl/score_calculator.sv
// -----------------------------------------------------------------------------
// score_calculator
// Game score / lives keeper for the score text overlay. Rising edges of the
// hit/miss/game_start levels drive a small game FSM; the displayed values are
// re-latched only on frame_start so the digits never change mid-frame.
//   clk    : system/pixel clock
//   reset  : synchronous, active-high
//   bus    : score_calculator_if.slave (events in, score/digits/lives/status out)
//
//   state | meaning
//   IDLE  | after reset, waiting for the first start edge
//   PLAY  | game running, hits score and misses cost lives
//   OVER  | lives exhausted, waiting for a start edge
// -----------------------------------------------------------------------------
module score_calculator
  import score_pkg::*;
#(
  parameter int POINTS_PER_HIT = 1,
  parameter int MAX_LIVES      = 3,
  parameter int MAX_SCORE      = 99
) (
  input logic                clk,
  input logic                reset,
  score_calculator_if.slave  bus
);

  if (!points_ok(POINTS_PER_HIT)) begin : g_bad_points
    $fatal(1, "POINTS_PER_HIT out of range 1..9");
  end
  if (!lives_ok(MAX_LIVES)) begin : g_bad_lives
    $fatal(1, "MAX_LIVES out of range 1..7");
  end
  if (!max_score_ok(MAX_SCORE)) begin : g_bad_max
    $fatal(1, "MAX_SCORE above 99");
  end

  localparam bcd_t               MAX_TENS   = bcd_t'(MAX_SCORE / 10);
  localparam bcd_t               MAX_ONES   = bcd_t'(MAX_SCORE % 10);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);
  localparam logic [3:0]         ADDEND     = 4'(POINTS_PER_HIT);

  game_state_t        r_state;
  logic               r_hist_start;
  logic               r_hist_hit;
  logic               r_hist_miss;
  bcd_t               r_tens;
  bcd_t               r_ones;
  logic [LIVES_W-1:0] r_lives;

  logic [SCORE_W-1:0] r_score;
  bcd_t               r_disp_tens;
  bcd_t               r_disp_ones;
  logic [LIVES_W-1:0] r_disp_lives;
  logic               r_playing;
  logic               r_game_over;

  logic               w_ev_start;
  logic               w_ev_hit;
  logic               w_ev_miss;
  bcd_t               w_add_tens;
  bcd_t               w_add_ones;
  logic [SCORE_W-1:0] w_bin;

  assign w_ev_start = bus.game_start  & ~r_hist_start;
  assign w_ev_hit   = bus.hit         & ~r_hist_hit;
  assign w_ev_miss  = bus.miss        & ~r_hist_miss;

  bcd2_add_sat u_add (
    .i_tens     (r_tens),
    .i_ones     (r_ones),
    .i_addend   (ADDEND),
    .i_max_tens (MAX_TENS),
    .i_max_ones (MAX_ONES),
    .o_tens     (w_add_tens),
    .o_ones     (w_add_ones)
  );

  // tens*10 + ones as tens*8 + tens*2 + ones; at most 99 so 7 bits suffice.
  assign w_bin = {r_tens, 3'b000} + {2'b00, r_tens, 1'b0} + {3'b000, r_ones};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hist_start <= 1'b0;
      r_hist_hit   <= 1'b0;
      r_hist_miss  <= 1'b0;
      r_tens       <= '0;
      r_ones       <= '0;
      r_lives      <= LIVES_INIT;
      r_score      <= '0;
      r_disp_tens  <= '0;
      r_disp_ones  <= '0;
      r_disp_lives <= LIVES_INIT;
      r_playing    <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_hist_start <= bus.game_start;
      r_hist_hit   <= bus.hit;
      r_hist_miss  <= bus.miss;

      // Display takes the working values from before this cycle's events.
      if (bus.frame_start) begin
        r_score      <= w_bin;
        r_disp_tens  <= r_tens;
        r_disp_ones  <= r_ones;
        r_disp_lives <= r_lives;
      end

      // A start edge overrides any hit/miss in the same cycle.
      if (w_ev_start) begin
        r_state     <= PLAY;
        r_tens      <= '0;
        r_ones      <= '0;
        r_lives     <= LIVES_INIT;
        r_playing   <= 1'b1;
        r_game_over <= 1'b0;
      end else if (r_state == PLAY) begin
        // Hit is scored even when a simultaneous miss ends the game.
        if (w_ev_hit) begin
          r_tens <= w_add_tens;
          r_ones <= w_add_ones;
        end
        if (w_ev_miss) begin
          if (r_lives == LIVES_W'(1)) begin
            r_lives     <= '0;
            r_state     <= OVER;
            r_playing   <= 1'b0;
            r_game_over <= 1'b1;
          end else begin
            r_lives <= r_lives - LIVES_W'(1);
          end
        end
      end
    end
  end

  assign bus.score      = r_score;
  assign bus.digit_tens = r_disp_tens;
  assign bus.digit_ones = r_disp_ones;
  assign bus.lives_left = r_disp_lives;
  assign bus.playing    = r_playing;
  assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_score_calculator.sv
// -----------------------------------------------------------------------------
// tb_score_calculator
// Two instances (1 and 7 points per hit) share one stimulus stream. A
// behavioural model with integer score/lives predicts every output each cycle;
// directed scenarios add literal expectations, then random stimulus runs.
// -----------------------------------------------------------------------------
module tb_score_calculator;

  typedef struct {
    int ws;  // working score
    int wl;  // working lives
    int st;  // 0 idle, 1 playing, 2 game over
    int ds;  // displayed score
    int dl;  // displayed lives
  } model_t;

  localparam int LIVES = 3;

  logic clk;
  logic reset;
  score_calculator_if if1 ();
  score_calculator_if if7 ();

  score_calculator #(.POINTS_PER_HIT(1), .MAX_LIVES(3), .MAX_SCORE(99)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  score_calculator #(.POINTS_PER_HIT(7), .MAX_LIVES(3), .MAX_SCORE(99)) u_dut7 (
    .clk   (clk),
    .reset (reset),
    .bus   (if7)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  model_t m1, m7;
  bit p_gs, p_hit, p_miss;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic model_t model_reset();
    model_t r;
    r.ws = 0; r.wl = LIVES; r.st = 0; r.ds = 0; r.dl = LIVES;
    return r;
  endfunction

  function automatic model_t step(input model_t c, input int p,
                                  input bit es, input bit eh, input bit em,
                                  input bit fs);
    model_t n;
    n = c;
    if (fs) begin
      n.ds = c.ws;
      n.dl = c.wl;
    end
    if (es) begin
      n.ws = 0;
      n.wl = LIVES;
      n.st = 1;
    end else if (c.st == 1) begin
      if (eh) n.ws = (c.ws + p > 99) ? 99 : c.ws + p;
      if (em) begin
        if (c.wl == 1) begin
          n.wl = 0;
          n.st = 2;
        end else begin
          n.wl = c.wl - 1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [19:0] expect_vec(input model_t d);
    return {7'(d.ds), 4'(d.ds / 10), 4'(d.ds % 10), 3'(d.dl),
            (d.st == 1), (d.st == 2)};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m1     <= model_reset();
      m7     <= model_reset();
      p_gs   <= 1'b0;
      p_hit  <= 1'b0;
      p_miss <= 1'b0;
    end else begin
      m1 <= step(m1, 1, if1.game_start & ~p_gs, if1.hit & ~p_hit,
                 if1.miss & ~p_miss, if1.frame_start);
      m7 <= step(m7, 7, if1.game_start & ~p_gs, if1.hit & ~p_hit,
                 if1.miss & ~p_miss, if1.frame_start);
      p_gs   <= if1.game_start;
      p_hit  <= if1.hit;
      p_miss <= if1.miss;
    end
  end

  task automatic cmp_vec(input string name, input logic [19:0] act,
                         input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got score=%0d tens=%0d ones=%0d lives=%0d play=%0b over=%0b want score=%0d tens=%0d ones=%0d lives=%0d play=%0b over=%0b",
               name, $time, act[19:13], act[12:9], act[8:5], act[4:2], act[1], act[0],
               exp[19:13], exp[12:9], exp[8:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_vec("model_p1", {if1.score, if1.digit_tens, if1.digit_ones,
                           if1.lives_left, if1.playing, if1.game_over}, expect_vec(m1));
      cmp_vec("model_p7", {if7.score, if7.digit_tens, if7.digit_ones,
                           if7.lives_left, if7.playing, if7.game_over}, expect_vec(m7));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Apply inputs just after a falling edge, then advance through one rising edge.
  task automatic cyc(input bit r, input bit gs, input bit h, input bit ms,
                     input bit fs);
    reset           = r;
    if1.game_start  = gs;  if7.game_start  = gs;
    if1.hit         = h;   if7.hit         = h;
    if1.miss        = ms;  if7.miss        = ms;
    if1.frame_start = fs;  if7.frame_start = fs;
    @(negedge clk);
  endtask

  task automatic idle(); cyc(0, 0, 0, 0, 0); endtask
  task automatic frame(); cyc(0, 0, 0, 0, 1); idle(); endtask
  task automatic start(); cyc(0, 1, 0, 0, 0); idle(); endtask
  task automatic hit_edge(); cyc(0, 0, 1, 0, 0); idle(); endtask
  task automatic miss_edge(); cyc(0, 0, 0, 1, 0); idle(); endtask

  initial begin
    bit gs, h, ms, fs, r;
    cyc(1, 0, 0, 0, 0);
    cmp_en = 1;
    cyc(1, 0, 0, 0, 0);

    // Reset state survives frame pulses with no events.
    repeat (3) frame();
    chk("rst_score", int'(if1.score), 0);
    chk("rst_tens", int'(if1.digit_tens), 0);
    chk("rst_ones", int'(if1.digit_ones), 0);
    chk("rst_lives", int'(if1.lives_left), 3);
    chk("rst_playing", int'(if1.playing), 0);
    chk("rst_over", int'(if1.game_over), 0);

    // Held hit counts once; display waits for frame_start.
    cyc(0, 1, 0, 0, 0);
    chk("start_playing", int'(if1.playing), 1);
    idle();
    repeat (20) cyc(0, 0, 1, 0, 0);
    chk("preframe_score", int'(if1.score), 0);
    cyc(0, 0, 0, 0, 1);
    chk("held_hit_score", int'(if1.score), 1);
    chk("held_hit_ones", int'(if1.digit_ones), 1);
    chk("held_hit_p7", int'(if7.score), 7);

    // Saturation at 99 with 7 points per hit.
    start();
    repeat (15) hit_edge();
    frame();
    chk("sat_score_p7", int'(if7.score), 99);
    chk("sat_tens_p7", int'(if7.digit_tens), 9);
    chk("sat_ones_p7", int'(if7.digit_ones), 9);
    chk("sat_score_p1", int'(if1.score), 15);
    chk("sat_tens_p1", int'(if1.digit_tens), 1);
    chk("sat_ones_p1", int'(if1.digit_ones), 5);

    // Running out of lives.
    start();
    repeat (2) hit_edge();
    repeat (2) miss_edge();
    chk("two_miss_playing", int'(if1.playing), 1);
    cyc(0, 0, 0, 1, 0);
    chk("third_miss_over", int'(if1.game_over), 1);
    chk("third_miss_playing", int'(if1.playing), 0);
    idle();
    frame();
    chk("over_lives", int'(if1.lives_left), 0);
    chk("over_score", int'(if1.score), 2);
    chk("over_score_p7", int'(if7.score), 14);
    hit_edge();
    frame();
    chk("over_hit_ignored", int'(if1.score), 2);

    // Hit and miss together on the last life; then start+hit+frame together.
    start();
    repeat (2) miss_edge();
    cyc(0, 0, 1, 1, 0);
    chk("hitmiss_over", int'(if1.game_over), 1);
    idle();
    frame();
    chk("hitmiss_score", int'(if1.score), 1);
    chk("hitmiss_lives", int'(if1.lives_left), 0);
    cyc(0, 1, 1, 0, 1);
    chk("startframe_score", int'(if1.score), 1);
    chk("startframe_lives", int'(if1.lives_left), 0);
    chk("startframe_playing", int'(if1.playing), 1);
    idle();
    frame();
    chk("restart_score", int'(if1.score), 0);
    chk("restart_lives", int'(if1.lives_left), 3);

    // Reset while 42 is displayed; hit held across reset release.
    start();
    repeat (42) hit_edge();
    frame();
    chk("s42_score", int'(if1.score), 42);
    chk("s42_tens", int'(if1.digit_tens), 4);
    chk("s42_ones", int'(if1.digit_ones), 2);
    cyc(1, 0, 1, 0, 0);
    chk("midrst_score", int'(if1.score), 0);
    chk("midrst_lives", int'(if1.lives_left), 3);
    chk("midrst_playing", int'(if1.playing), 0);
    chk("midrst_tens", int'(if1.digit_tens), 0);
    repeat (3) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("held_across_rst_score", int'(if1.score), 0);
    chk("held_across_rst_play", int'(if1.playing), 1);

    // Random stimulus against the model.
    gs = 0; h = 0; ms = 0;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) gs = ~gs;
      if ($urandom_range(0, 2) == 0)  h  = ~h;
      if ($urandom_range(0, 9) == 0)  ms = ~ms;
      fs = ($urandom_range(0, 11) == 0);
      cyc(r, gs, h, ms, fs);
    end

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
